// File: rtl/multicycle_control_unit_if.sv
// Memory bus between the multicycle control unit and instruction/operand memory.
//   mem_req   : access request, held with mem_we/mem_addr until mem_ack
//   mem_we    : write strobe, qualifies mem_req
//   mem_addr  : word address
//   mem_ack   : transfer complete (may arrive in the request cycle)
//   mem_rdata : read data, valid with mem_ack
// master = control unit, slave = memory.
interface multicycle_control_unit_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the accumulator datapath. Owns PC and IR, fetches
// over the req/ack memory bus, decodes the opcode, issues operand accesses and
// accumulator writebacks, resolves SKIP/JUMP, halts, counts retired
// instructions and flags illegal opcodes (sticky).
// Ports:
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   run               : start execution from IDLE
//   mem               : memory bus (master side)
//   zero_flag         : accumulator == 0, sampled only by SKIP in DECODE
//   mdr               : latched memory operand
//   reg_write_enable  : accumulator write strobe (WB only)
//   alu_op            : operation for the accumulator write (WB only)
//   pc, ir            : program counter, instruction register
//   halt, illegal     : halted, sticky illegal-opcode flag
//   retired           : retired-instruction count (wraps)
module multicycle_control_unit #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              run,
  multicycle_control_unit_if.master         mem,
  input  logic                              zero_flag,
  output logic [WORD_W-1:0]                 mdr,
  output logic                              reg_write_enable,
  output logic [OPC_W-1:0]                  alu_op,
  output logic [ADDR_W-1:0]                 pc,
  output logic [WORD_W-1:0]                 ir,
  output logic                              halt,
  output logic                              illegal,
  output logic [CNT_W-1:0]                  retired
);

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(4'b1000);
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'b1001);
  localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4'b1010);
  localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(4'b1011);
  localparam logic [OPC_W-1:0] OP_CLEAR = OPC_W'(4'b1100);
  localparam logic [OPC_W-1:0] OP_SKIP  = OPC_W'(4'b1101);
  localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(4'b1110);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM,
    WB,
    HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0]   ir_q, ir_d;
  logic [WORD_W-1:0]   mdr_q, mdr_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic                retire;
  logic                mem_req_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic                rwe_c;
  logic [OPC_W-1:0]    alu_op_c;

  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;

  assign opcode  = ir_q[WORD_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = '0;
    rwe_c      = 1'b0;
    alu_op_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end

      FETCH: begin
        mem_req_c  = 1'b1;
        mem_addr_c = pc_q;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_ADD, OP_LOAD, OP_STORE: state_d = MEM;
          OP_CLEAR:                  state_d = WB;
          OP_SKIP: begin
            if (zero_flag) pc_d = pc_q + ADDR_W'(1);
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_JUMP: begin
            pc_d    = operand;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = HALTED;
          end
          default: begin
            illegal_d = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end

      MEM: begin
        mem_req_c  = 1'b1;
        mem_addr_c = operand;
        mem_we_c   = (opcode == OP_STORE);
        if (mem.mem_ack) begin
          if (opcode == OP_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = WB;
          end
        end
      end

      WB: begin
        rwe_c    = 1'b1;
        alu_op_c = opcode;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      HALTED: ;

      default: state_d = IDLE;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Bus outputs decode from the state register only, so an asynchronous
  // reset drops mem_req in the same cycle.
  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr     = mem_addr_c;
  assign reg_write_enable = rwe_c;
  assign alu_op           = alu_op_c;
  assign mdr              = mdr_q;
  assign pc               = pc_q;
  assign ir               = ir_q;
  assign halt             = (state_q == HALTED);
  assign illegal          = illegal_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a memory responder with programmable ack
// delay, expected bus accesses and writebacks queued per program and
// compared as the unit produces them, plus direct state checks.
module tb_multicycle_control_unit;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              run = 1'b0;
  logic              zero_flag = 1'b0;
  logic [WORD_W-1:0] mdr;
  logic              reg_write_enable;
  logic [OPC_W-1:0]  alu_op;
  logic [ADDR_W-1:0] pc;
  logic [WORD_W-1:0] ir;
  logic              halt;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  multicycle_control_unit_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  multicycle_control_unit #(
    .WORD_W(WORD_W), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem(bus),
    .zero_flag(zero_flag), .mdr(mdr), .reg_write_enable(reg_write_enable),
    .alu_op(alu_op), .pc(pc), .ir(ir), .halt(halt), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory responder
  logic [WORD_W-1:0] mem_arr [0:(1<<ADDR_W)-1];
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  logic        force_ack = 1'b0;

  assign bus.mem_ack   = (bus.mem_req && (wcnt == ack_delay)) || force_ack;
  assign bus.mem_rdata = mem_arr[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboards: {we, addr} per accepted access, {alu_op, mdr} per writeback
  logic [ADDR_W:0]         acc_q [$];
  logic [OPC_W+WORD_W-1:0] wb_q  [$];

  logic            prev_hold = 1'b0;
  logic [ADDR_W:0] prev_acc  = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.mem_req && prev_hold)
        check("hold_stable", 32'({bus.mem_we, bus.mem_addr}), 32'(prev_acc));
      if (bus.mem_req && bus.mem_ack) begin
        check("acc_expected", 32'(acc_q.size() != 0), 1);
        if (acc_q.size() != 0)
          check("acc_we_addr", 32'({bus.mem_we, bus.mem_addr}), 32'(acc_q.pop_front()));
        prev_hold = 1'b0;
      end else begin
        prev_hold = bus.mem_req;
        prev_acc  = {bus.mem_we, bus.mem_addr};
      end
      if (reg_write_enable) begin
        check("wb_expected", 32'(wb_q.size() != 0), 1);
        if (wb_q.size() != 0)
          check("wb_op_mdr", 32'({alu_op, mdr}), 32'(wb_q.pop_front()));
      end else begin
        check("alu_op_idle", 32'(alu_op), 0);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem_arr[i] = '0;
  endtask

  task automatic do_reset();
    run = 1'b0;
    force_ack = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic push_acc(input logic we, input logic [ADDR_W-1:0] a);
    acc_q.push_back({we, a});
  endtask

  task automatic push_wb(input logic [OPC_W-1:0] op, input logic [WORD_W-1:0] d);
    wb_q.push_back({op, d});
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(halt), 1);
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, input int budget);
    int n = 0;
    while (!(bus.mem_req && bus.mem_addr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("addr_reached", 32'(bus.mem_req && bus.mem_addr == a), 1);
  endtask

  task automatic end_test();
    check("acc_queue_drained", 32'(acc_q.size()), 0);
    check("wb_queue_drained", 32'(wb_q.size()), 0);
    acc_q.delete();
    wb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int fs, wbc;
    logic bad;

    // T1: LOAD 5 with zero-wait memory, then HALT
    clear_mem();
    ack_delay = 0;
    mem_arr[0] = 16'hA005;
    mem_arr[1] = 16'h9000;
    mem_arr[5] = 16'h1234;
    do_reset();
    check("rst_pc", 32'(pc), 0);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_ir", 32'(ir), 0);
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'h005);
    push_acc(1'b0, 12'h001);
    push_wb(4'hA, 16'h1234);
    pulse_run();
    fs = -1;
    wbc = -1;
    for (int n = 0; n < 20; n++) begin
      if (bus.mem_req && fs < 0) fs = n;
      if (reg_write_enable) begin
        wbc = n;
        break;
      end
      @(negedge clk);
    end
    check("t1_wb_offset", 32'(wbc - fs), 3);
    check("t1_alu_op", 32'(alu_op), 32'h0A);
    check("t1_mdr", 32'(mdr), 32'h1234);
    @(negedge clk);
    check("t1_rwe_one_cycle", 32'(reg_write_enable), 0);
    check("t1_pc", 32'(pc), 1);
    check("t1_retired", 32'(retired), 1);
    wait_halt(50);
    check("t1_pc_halt", 32'(pc), 2);
    check("t1_retired_halt", 32'(retired), 2);
    end_test();

    // T2: LOAD/ADD/STORE/HALT with 3-cycle ack delay
    clear_mem();
    ack_delay = 3;
    mem_arr[0] = 16'hA005;
    mem_arr[1] = 16'h8006;
    mem_arr[2] = 16'hB007;
    mem_arr[3] = 16'h9000;
    mem_arr[5] = 16'h0011;
    mem_arr[6] = 16'h0022;
    do_reset();
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'h005);
    push_acc(1'b0, 12'h001);
    push_acc(1'b0, 12'h006);
    push_acc(1'b0, 12'h002);
    push_acc(1'b1, 12'h007);
    push_acc(1'b0, 12'h003);
    push_wb(4'hA, 16'h0011);
    push_wb(4'h8, 16'h0022);
    pulse_run();
    wait_halt(200);
    check("t2_retired", 32'(retired), 4);
    check("t2_pc", 32'(pc), 4);
    bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      run = ~run;
      force_ack = ~force_ack;
      @(negedge clk);
      bad = bad | bus.mem_req | reg_write_enable;
    end
    run = 1'b0;
    force_ack = 1'b0;
    check("t2_halted_quiet", 32'(bad), 0);
    check("t2_halt_kept", 32'(halt), 1);
    check("t2_retired_kept", 32'(retired), 4);
    end_test();

    // T3: JUMP 0xFFF, SKIP at 0xFFF with zero_flag=1 wraps pc to 1
    clear_mem();
    ack_delay = 0;
    zero_flag = 1'b1;
    mem_arr[0]     = 16'hEFFF;
    mem_arr[12'hFFF] = 16'hD000;
    mem_arr[1]     = 16'h9000;
    do_reset();
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'hFFF);
    push_acc(1'b0, 12'h001);
    pulse_run();
    wait_addr(12'hFFF, 20);
    check("t3_pc_after_jump", 32'(pc), 32'hFFF);
    wait_addr(12'h001, 20);
    check("t3_pc_after_skip", 32'(pc), 1);
    wait_halt(20);
    check("t3_pc_halt", 32'(pc), 2);
    check("t3_retired", 32'(retired), 3);
    end_test();

    // T4: SKIP with zero_flag=0 falls through, no writeback
    clear_mem();
    zero_flag = 1'b0;
    mem_arr[0] = 16'hD000;
    mem_arr[1] = 16'h9000;
    mem_arr[2] = 16'h9000;
    do_reset();
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'h001);
    pulse_run();
    wait_halt(20);
    check("t4_pc", 32'(pc), 2);
    check("t4_retired", 32'(retired), 2);
    end_test();

    // T5: illegal opcode 0x3, then CLEAR, then HALT
    clear_mem();
    mem_arr[0] = 16'h3000;
    mem_arr[1] = 16'hC000;
    mem_arr[2] = 16'h9000;
    do_reset();
    check("t5_illegal_rst", 32'(illegal), 0);
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'h001);
    push_acc(1'b0, 12'h002);
    push_wb(4'hC, 16'h0000);
    pulse_run();
    wait_addr(12'h001, 20);
    check("t5_illegal_set", 32'(illegal), 1);
    check("t5_pc", 32'(pc), 1);
    check("t5_retired_illegal", 32'(retired), 1);
    wait_halt(20);
    check("t5_illegal_sticky", 32'(illegal), 1);
    check("t5_retired", 32'(retired), 3);
    check("t5_pc_halt", 32'(pc), 3);
    end_test();

    // T6: reset while MEM waits for ack
    clear_mem();
    ack_delay = 3;
    mem_arr[0] = 16'hA005;
    mem_arr[1] = 16'h9000;
    mem_arr[5] = 16'hBEEF;
    do_reset();
    push_acc(1'b0, 12'h000);
    pulse_run();
    wait_addr(12'h005, 30);
    check("t6_in_mem_pc", 32'(pc), 1);
    reset_n = 1'b0;
    #1;
    check("t6_req_drop", 32'(bus.mem_req), 0);
    check("t6_we", 32'(bus.mem_we), 0);
    check("t6_addr", 32'(bus.mem_addr), 0);
    check("t6_pc", 32'(pc), 0);
    check("t6_ir", 32'(ir), 0);
    check("t6_mdr", 32'(mdr), 0);
    check("t6_retired", 32'(retired), 0);
    check("t6_outs", 32'({halt, illegal, reg_write_enable, alu_op}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      bad = bad | bus.mem_req;
    end
    check("t6_idle_needs_run", 32'(bad), 0);
    end_test();
    push_acc(1'b0, 12'h000);
    push_acc(1'b0, 12'h005);
    push_acc(1'b0, 12'h001);
    push_wb(4'hA, 16'hBEEF);
    pulse_run();
    wait_halt(100);
    check("t6_retired_rerun", 32'(retired), 2);
    end_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
